// File: rtl/tx_packetizer_pkg.sv
// -----------------------------------------------------------------------------
// tx_packetizer_pkg
// Shared definitions for the ADC-to-UART packetizer: FSM state encoding,
// the byte-phase codes that track which byte of a frame is on the line, and
// the default frame header value.
// -----------------------------------------------------------------------------
package tx_packetizer_pkg;

    // First byte of every frame unless overridden at instantiation.
    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_NEXT
    } state_e;

    // Which byte of the frame d_o currently holds.
    typedef enum logic [1:0] {
        PH_HDR,
        PH_MSB,
        PH_LSB,
        PH_CKS
    } phase_e;

endpackage : tx_packetizer_pkg

// File: rtl/tx_packetizer_sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Small synchronous show-ahead FIFO that decouples ADC capture from the UART
// byte rate. rd_data always presents the oldest entry while empty is low.
//
// Ports
//   clk      in   1      system clock, rising edge
//   rst      in   1      synchronous active-high reset; empties the FIFO
//   push     in   1      write wr_data (ignored when full unless popping)
//   wr_data  in   Width  data to store
//   pop      in   1      discard the oldest entry (ignored when empty)
//   rd_data  out  Width  oldest entry
//   full     out  1      Depth entries stored
//   empty    out  1      no entries stored
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4   // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wr_data,
    input  logic             pop,
    output logic [Width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PtrW+1)'(Depth));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push on a full FIFO is legal then.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are log2(Depth) wide, so they wrap modulo Depth for free.
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PtrW+1)'(1);
                2'b01:   count <= count - (PtrW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale contents are never observed
    // because empty gates every read, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule : sample_fifo

// File: rtl/tx_packetizer.sv
// -----------------------------------------------------------------------------
// tx_packetizer
// Frames 16-bit ADC samples into bytes for the RS-232 transmitter:
//   header, NumSamples x (MSB, LSB), 8-bit checksum of the sample bytes.
// Drives the transmitter's start / data / end-of-transmission handshake.
//
// Ports
//   clk_i     in   1   system clock, rising edge
//   rst_i     in   1   synchronous active-high reset
//   sample_i  in   16  ADC sample
//   valid_i   in   1   sample_i valid; accepted when valid_i & ready_o
//   ready_o   out  1   sample FIFO not full
//   st_o      out  1   one-cycle start pulse to the transmitter
//   d_o       out  8   byte to transmit; held from st_o until eot_i is high again
//   eot_i     in   1   transmitter level: 1 = idle/done, 0 = sending
//   busy_o    out  1   frame in progress
//   frame_o   out  1   one-cycle pulse after the checksum byte completes
// -----------------------------------------------------------------------------
module tx_packetizer
    import tx_packetizer_pkg::*;
#(
    parameter int         NumSamples = 31,          // 1..255
    parameter logic [7:0] Header     = HDR_DEFAULT,
    parameter int         FifoDepth  = 4            // power of 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] sample_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        st_o,
    output logic [7:0]  d_o,
    input  logic        eot_i,
    output logic        busy_o,
    output logic        frame_o
);

    localparam int CntW = $clog2(NumSamples + 1);

    // FIFO interface
    logic        fifo_pop;
    logic [15:0] fifo_rd_data;
    logic        fifo_full;
    logic        fifo_empty;

    // Registered state and its next-state values
    state_e            state,   state_next;
    phase_e            phase,   phase_next;
    logic [CntW-1:0]   cnt,     cnt_next;
    logic [7:0]        cks,     cks_next;
    logic [7:0]        d_q,     d_next;
    logic [7:0]        lsb_q,   lsb_next;
    logic              st_q,    st_next;
    logic              frame_q, frame_next;

    // ready_o is taken before any same-cycle pop, so a full FIFO never pushes.
    assign ready_o = !fifo_full;

    sample_fifo #(
        .Width (16),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (valid_i && ready_o),
        .wr_data (sample_i),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            phase   <= PH_HDR;
            cnt     <= '0;
            cks     <= '0;
            d_q     <= '0;
            lsb_q   <= '0;
            st_q    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            cnt     <= cnt_next;
            cks     <= cks_next;
            d_q     <= d_next;
            lsb_q   <= lsb_next;
            st_q    <= st_next;
            frame_q <= frame_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_next = state;
        phase_next = phase;
        cnt_next   = cnt;
        cks_next   = cks;
        d_next     = d_q;
        lsb_next   = lsb_q;
        st_next    = 1'b0;
        frame_next = 1'b0;
        fifo_pop   = 1'b0;

        case (state)
            // A frame only opens once there is at least one sample to follow
            // the header.
            ST_IDLE: begin
                if (!fifo_empty) begin
                    d_next     = Header;
                    cks_next   = '0;
                    cnt_next   = '0;
                    phase_next = PH_HDR;
                    state_next = ST_SEND;
                end
            end

            // Stalls here on FIFO underrun; the line just idles between bytes.
            ST_LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    d_next     = fifo_rd_data[15:8];
                    lsb_next   = fifo_rd_data[7:0];
                    cnt_next   = cnt + CntW'(1);
                    phase_next = PH_MSB;
                    state_next = ST_SEND;
                end
            end

            // Start only into an idle transmitter. Sample bytes join the
            // checksum as their start pulse is issued.
            ST_SEND: begin
                if (eot_i) begin
                    st_next = 1'b1;
                    if (phase == PH_MSB || phase == PH_LSB) begin
                        cks_next = cks + d_q;
                    end
                    state_next = ST_WAIT_LO;
                end
            end

            ST_WAIT_LO: begin
                if (!eot_i) state_next = ST_WAIT_HI;
            end

            ST_WAIT_HI: begin
                if (eot_i) state_next = ST_NEXT;
            end

            ST_NEXT: begin
                case (phase)
                    PH_HDR: state_next = ST_LOAD;
                    PH_MSB: begin
                        d_next     = lsb_q;
                        phase_next = PH_LSB;
                        state_next = ST_SEND;
                    end
                    PH_LSB: begin
                        if (cnt == CntW'(NumSamples)) begin
                            d_next     = cks;
                            phase_next = PH_CKS;
                            state_next = ST_SEND;
                        end else begin
                            state_next = ST_LOAD;
                        end
                    end
                    PH_CKS: begin
                        frame_next = 1'b1;
                        state_next = ST_IDLE;
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign st_o    = st_q;
    assign d_o     = d_q;
    assign frame_o = frame_q;
    assign busy_o  = (state != ST_IDLE);

endmodule : tx_packetizer

// File: tb/tb_tx_packetizer.sv
// -----------------------------------------------------------------------------
// tb_tx_packetizer
// Directed bench for tx_packetizer with NumSamples=3. A behavioural UART
// drops eot for 10 cycles (or 50 on request) after each start pulse and logs
// every byte it is handed. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tx_packetizer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] sample_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        st_o;
    logic [7:0]  d_o;
    logic        eot_i = 1'b1;
    logic        busy_o;
    logic        frame_o;

    int checks   = 0;
    int failures = 0;

    // UART model state
    logic [7:0] byte_q [$];
    logic [7:0] cur_byte = '0;
    int frame_cnt     = 0;
    int st_while_busy = 0;
    int stab_viol     = 0;
    int busy_cnt      = 0;
    int long_req      = 0;   // written by tests only
    int long_done     = 0;   // written by the model only

    always #5 clk_i = ~clk_i;

    tx_packetizer #(
        .NumSamples (3),
        .Header     (8'hA5),
        .FifoDepth  (4)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sample_i (sample_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .st_o     (st_o),
        .d_o      (d_o),
        .eot_i    (eot_i),
        .busy_o   (busy_o),
        .frame_o  (frame_o)
    );

    // Behavioural transmitter: takes a byte on st_o, stays busy, then idles.
    always @(negedge clk_i) begin
        if (st_o === 1'b1) begin
            if (eot_i !== 1'b1) st_while_busy++;
            byte_q.push_back(d_o);
            cur_byte = d_o;
            if (long_req > long_done) begin
                busy_cnt = 50;
                long_done++;
            end else begin
                busy_cnt = 10;
            end
            eot_i = 1'b0;
        end else if (busy_cnt > 0) begin
            if (d_o !== cur_byte) stab_viol++;
            busy_cnt--;
            if (busy_cnt == 0) eot_i = 1'b1;
        end
        if (frame_o === 1'b1) frame_cnt++;
    end

    // Caller is at a falling edge; returns at the falling edge after acceptance.
    task automatic push(input logic [15:0] s, output bit ok);
        int n = 0;
        sample_i = s;
        valid_i  = 1'b1;
        while (ready_o !== 1'b1 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        ok = (ready_o === 1'b1);
        @(negedge clk_i);
    endtask

    task automatic wait_frames(input int target, output bit ok);
        int n = 0;
        while (frame_cnt < target && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        ok = (frame_cnt >= target);
        @(negedge clk_i);
    endtask

    task automatic wait_bytes(input int target, output bit ok);
        int n = 0;
        while (byte_q.size() < target && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        ok = (byte_q.size() >= target);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++; if (st_o !== 1'b0) begin failures++; $display("FAIL reset_st: got %b expected 0", st_o); end
        checks++; if (d_o !== 8'h00) begin failures++; $display("FAIL reset_d: got %h expected 00", d_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (frame_o !== 1'b0) begin failures++; $display("FAIL reset_frame: got %b expected 0", frame_o); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_b [8] = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hAB, 8'hCD, 8'hBD};
        int b  = byte_q.size();
        int fb = frame_cnt;
        bit ok;
        // Three back-to-back pushes; also pins the IDLE->SEND->st_o latency.
        sample_i = 16'h1234; valid_i = 1'b1;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL t1_lat_busy0: got %b expected 0", busy_o); end
        sample_i = 16'h00FF;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1 || st_o !== 1'b0) begin failures++; $display("FAIL t1_lat_send: busy=%b st=%b expected busy=1 st=0", busy_o, st_o); end
        sample_i = 16'hABCD;
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++; if (st_o !== 1'b1 || d_o !== 8'hA5) begin failures++; $display("FAIL t1_lat_st: st=%b d=%h expected st=1 d=a5", st_o, d_o); end
        wait_frames(fb + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t1_timeout: frames got %0d expected %0d", frame_cnt - fb, 1); end
        repeat (5) @(negedge clk_i);
        checks++; if (byte_q.size() - b !== 8) begin failures++; $display("FAIL t1_len: got %0d expected 8", byte_q.size() - b); end
        for (int i = 0; i < 8; i++) begin
            if (b + i < byte_q.size()) begin
                checks++;
                if (byte_q[b+i] !== exp_b[i]) begin failures++; $display("FAIL t1_byte%0d: got %h expected %h", i, byte_q[b+i], exp_b[i]); end
            end
        end
        checks++; if (frame_cnt - fb !== 1) begin failures++; $display("FAIL t1_frames: got %0d expected 1", frame_cnt - fb); end
        checks++; if (st_while_busy !== 0) begin failures++; $display("FAIL t1_st_busy: got %0d expected 0", st_while_busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s [6] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C};
        logic [7:0] exp_b [16] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15,
                                   8'hA5, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h39};
        int b  = byte_q.size();
        int fb = frame_cnt;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            push(s[i], ok);
            checks++; if (!ok) begin failures++; $display("FAIL t2_push%0d: ready got %b expected 1", i, ready_o); end
            if (i == 3) begin
                checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL t2_full: ready got %b expected 0", ready_o); end
            end
        end
        valid_i = 1'b0;
        wait_frames(fb + 2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t2_timeout: frames got %0d expected 2", frame_cnt - fb); end
        repeat (5) @(negedge clk_i);
        checks++; if (byte_q.size() - b !== 16) begin failures++; $display("FAIL t2_len: got %0d expected 16", byte_q.size() - b); end
        for (int i = 0; i < 16; i++) begin
            if (b + i < byte_q.size()) begin
                checks++;
                if (byte_q[b+i] !== exp_b[i]) begin failures++; $display("FAIL t2_byte%0d: got %h expected %h", i, byte_q[b+i], exp_b[i]); end
            end
        end
        checks++; if (frame_cnt - fb !== 2) begin failures++; $display("FAIL t2_frames: got %0d expected 2", frame_cnt - fb); end
    endtask

    task automatic test_underrun();
        logic [7:0] exp_b [8] = '{8'hA5, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h97};
        int b  = byte_q.size();
        int fb = frame_cnt;
        bit ok;
        push(16'h4455, ok);
        valid_i = 1'b0;
        repeat (200) @(negedge clk_i);
        checks++; if (byte_q.size() - b !== 3) begin failures++; $display("FAIL t3_stall_len: got %0d expected 3", byte_q.size() - b); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL t3_stall_busy: got %b expected 1", busy_o); end
        checks++; if (frame_cnt - fb !== 0) begin failures++; $display("FAIL t3_stall_frame: got %0d expected 0", frame_cnt - fb); end
        push(16'h6677, ok);
        push(16'h8899, ok);
        valid_i = 1'b0;
        wait_frames(fb + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t3_timeout: frames got %0d expected 1", frame_cnt - fb); end
        repeat (5) @(negedge clk_i);
        checks++; if (byte_q.size() - b !== 8) begin failures++; $display("FAIL t3_len: got %0d expected 8", byte_q.size() - b); end
        for (int i = 0; i < 8; i++) begin
            if (b + i < byte_q.size()) begin
                checks++;
                if (byte_q[b+i] !== exp_b[i]) begin failures++; $display("FAIL t3_byte%0d: got %h expected %h", i, byte_q[b+i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_eot_hold();
        logic [7:0] exp_b [8] = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
        int b  = byte_q.size();
        int fb = frame_cnt;
        int vb = stab_viol;
        bit ok;
        long_req++;   // header byte keeps the line busy for 50 cycles
        push(16'h0011, ok);
        push(16'h2233, ok);
        push(16'h4455, ok);
        valid_i = 1'b0;
        wait_bytes(b + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t4_first_timeout: got %0d bytes expected 1", byte_q.size() - b); end
        repeat (45) @(negedge clk_i);
        checks++; if (byte_q.size() - b !== 1) begin failures++; $display("FAIL t4_hold_len: got %0d expected 1", byte_q.size() - b); end
        checks++; if (eot_i !== 1'b0 || st_o !== 1'b0) begin failures++; $display("FAIL t4_hold_st: eot=%b st=%b expected eot=0 st=0", eot_i, st_o); end
        checks++; if (d_o !== 8'hA5) begin failures++; $display("FAIL t4_hold_d: got %h expected a5", d_o); end
        wait_frames(fb + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t4_timeout: frames got %0d expected 1", frame_cnt - fb); end
        repeat (5) @(negedge clk_i);
        checks++; if (byte_q.size() - b !== 8) begin failures++; $display("FAIL t4_len: got %0d expected 8", byte_q.size() - b); end
        for (int i = 0; i < 8; i++) begin
            if (b + i < byte_q.size()) begin
                checks++;
                if (byte_q[b+i] !== exp_b[i]) begin failures++; $display("FAIL t4_byte%0d: got %h expected %h", i, byte_q[b+i], exp_b[i]); end
            end
        end
        checks++; if (stab_viol - vb !== 0) begin failures++; $display("FAIL t4_d_stable: got %0d changes expected 0", stab_viol - vb); end
        checks++; if (st_while_busy !== 0) begin failures++; $display("FAIL t4_st_busy: got %0d expected 0", st_while_busy); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [8] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
        int b  = byte_q.size();
        int fb = frame_cnt;
        int b2;
        bit ok;
        push(16'h1111, ok);
        push(16'h2222, ok);
        push(16'h3333, ok);
        valid_i = 1'b0;
        wait_bytes(b + 4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t5_4th_timeout: got %0d bytes expected 4", byte_q.size() - b); end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b1 || st_o !== 1'b0) begin
            failures++; $display("FAIL t5_rst_out: busy=%b ready=%b st=%b expected busy=0 ready=1 st=0", busy_o, ready_o, st_o);
        end
        checks++; if (d_o !== 8'h00) begin failures++; $display("FAIL t5_rst_d: got %h expected 00", d_o); end
        rst_i = 1'b0;
        b2 = byte_q.size();
        // A flushed FIFO means the leftover third sample never starts a frame.
        repeat (40) @(negedge clk_i);
        checks++; if (byte_q.size() !== b2 || busy_o !== 1'b0) begin
            failures++; $display("FAIL t5_flush: new bytes=%0d busy=%b expected 0 and 0", byte_q.size() - b2, busy_o);
        end
        checks++; if (frame_cnt - fb !== 0) begin failures++; $display("FAIL t5_no_frame: got %0d expected 0", frame_cnt - fb); end
        push(16'h0102, ok);
        push(16'h0304, ok);
        push(16'h0506, ok);
        valid_i = 1'b0;
        wait_frames(fb + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t5_timeout: frames got %0d expected 1", frame_cnt - fb); end
        repeat (5) @(negedge clk_i);
        checks++; if (byte_q.size() - b2 !== 8) begin failures++; $display("FAIL t5_len: got %0d expected 8", byte_q.size() - b2); end
        for (int i = 0; i < 8; i++) begin
            if (b2 + i < byte_q.size()) begin
                checks++;
                if (byte_q[b2+i] !== exp_b[i]) begin failures++; $display("FAIL t5_byte%0d: got %h expected %h", i, byte_q[b2+i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_checksum_wrap();
        logic [7:0] exp_b [8] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFA};
        int b  = byte_q.size();
        int fb = frame_cnt;
        bit ok;
        for (int i = 0; i < 3; i++) push(16'hFFFF, ok);
        valid_i = 1'b0;
        wait_frames(fb + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t6_timeout: frames got %0d expected 1", frame_cnt - fb); end
        repeat (5) @(negedge clk_i);
        checks++; if (byte_q.size() - b !== 8) begin failures++; $display("FAIL t6_len: got %0d expected 8", byte_q.size() - b); end
        for (int i = 0; i < 8; i++) begin
            if (b + i < byte_q.size()) begin
                checks++;
                if (byte_q[b+i] !== exp_b[i]) begin failures++; $display("FAIL t6_byte%0d: got %h expected %h", i, byte_q[b+i], exp_b[i]); end
            end
        end
        checks++; if (st_while_busy !== 0) begin failures++; $display("FAIL t6_st_busy: got %0d expected 0", st_while_busy); end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_underrun();
        test_eot_hold();
        test_reset_mid();
        test_checksum_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop in case a wait loop is ever broken by a DUT that stops the clock path.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_tx_packetizer
